// File: rtl/md_pkg.sv
// md_pkg: shared encodings, latency defaults and FSM states for the multiply/divide unit
package md_pkg;
  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF = 10;
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } md_op_e;
  typedef enum logic {IDLE, RUN} state_e;
  function automatic logic is_muldiv(input logic [2:0] op);
    return !op[2];
  endfunction
endpackage

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: request/result bundle between the pipeline and the multiply/divide unit
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, md_op, src_a, src_b, input busy, hi, lo);
  modport slave (input start, md_op, src_a, src_b, output busy, hi, lo);
endinterface

// File: rtl/md_arith.sv
// md_arith: combinational {hi,lo} result for mult/multu/div/divu, MIPS divide corner cases included
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [63:0] res
);
  logic signed [31:0] sa, sb;
  logic signed [63:0] sprod;
  logic [63:0] uprod;
  logic [31:0] sq, sr, uq, ur;
  logic div0, ovf;
  always_comb begin
    sa = src_a;
    sb = src_b;
    sprod = 64'(sa) * 64'(sb);
    uprod = {32'd0, src_a} * {32'd0, src_b};
    div0 = src_b == 32'd0;
    // quotient truncates toward zero; remainder carries the dividend's sign
    ovf = src_a == 32'h8000_0000 && src_b == 32'hFFFF_FFFF;
    sq = div0 || ovf ? 32'd0 : 32'(sa / sb);
    sr = div0 || ovf ? 32'd0 : 32'(sa % sb);
    uq = div0 ? 32'd0 : src_a / src_b;
    ur = div0 ? 32'd0 : src_a % src_b;
    res = md_op == OP_MULT  ? sprod :
          md_op == OP_MULTU ? uprod :
          md_op[2] ? 64'd0 :
          div0 ? {src_a, 32'hFFFF_FFFF} :
          md_op == OP_DIVU ? {ur, uq} :
          ovf ? {32'd0, 32'h8000_0000} : {sr, sq};
  end
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle mult/div sequencer holding HI/LO; result lands when busy falls
module mdu_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC = DIV_CYC_DEF
) (
  input logic clk,
  input logic reset,
  mdu_ctrl_if.slave bus
);
  localparam int LAT = DIV_CYC > MULT_CYC ? DIV_CYC : MULT_CYC;
  localparam int CW = $clog2(LAT + 1) > 4 ? $clog2(LAT + 1) : 4;
  state_e state;
  logic [CW-1:0] cnt;
  logic [63:0] pend, res;
  md_arith u_arith (.md_op(bus.md_op), .src_a(bus.src_a), .src_b(bus.src_b), .res(res));
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.hi <= '0;
      bus.lo <= '0;
      cnt <= '0;
      pend <= '0;
    end else if (state == IDLE) begin
      if (bus.start && is_muldiv(bus.md_op)) begin
        state <= RUN;
        bus.busy <= 1'b1;
        pend <= res;
        cnt <= bus.md_op[1] ? CW'(DIV_CYC) : CW'(MULT_CYC);
      end else if (bus.start && bus.md_op == OP_MTHI) bus.hi <= bus.src_a;
      else if (bus.start && bus.md_op == OP_MTLO) bus.lo <= bus.src_a;
    end else if (cnt == CW'(1)) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.hi <= pend[63:32];
      bus.lo <= pend[31:0];
      cnt <= '0;
    end else if (cnt != '0) cnt <= cnt - CW'(1);
  end
endmodule
